keypad_debounce_encoder: RTL and testbench
==========================================

Name: keypad_debounce_encoder

Overview:
- Parametrised successor to the combinational keypad priority encoder.
- Encodes NUM_KEYS active-high key lines, highest index wins, then debounces the winning code over DEBOUNCE_CYCLES clocks.
- Holds the registered code while the key is pressed, and issues one press event per debounced press through a valid/ack handshake.
- Sits between the raw keypad inputs and the digit-entry/control logic.
- Keeps the legacy output sense: V=1 means no valid key, and enablen is active-low.

Parameters:
- NUM_KEYS, 10, number of key lines. Legal range 2..16.
- CODE_W, 4, width of the code outputs. Requirement: 2**CODE_W >= NUM_KEYS.
- DEBOUNCE_CYCLES, 4, consecutive stable samples required for press and for release. Must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- keypad  input  NUM_KEYS  raw key lines, 1 = pressed.
- enablen  input  1  active-low enable.
- evt_ack  input  1  consumer acknowledge of the pending event.
- D  output  CODE_W  debounced held key code (registered).
- V  output  1  1 = no debounced key held, 0 = D valid (registered).
- evt_valid  output  1  press event pending.
- evt_code  output  CODE_W  code of the pending event.
- overrun  output  1  sticky: a press event was dropped while evt_valid was high.

Behaviour:
- Reset (synchronous, active-high) has priority over everything. On reset:
  - state=IDLE, cnt=0, cand=0
  - D=0, V=1
  - evt_valid=0, evt_code=0, overrun=0
- Raw encode, evaluated every cycle:
  - raw_any = |keypad
  - raw_code = highest set index; 0 when raw_any=0
- enablen=1 (not in reset):
  - state forced to IDLE, cnt=0, D=0, V=1.
  - evt_valid, evt_code and overrun are retained.
  - evt_ack is still honoured.
- State IDLE: if raw_any, then cand<=raw_code, cnt<=0, go to DEBOUNCE.
- State DEBOUNCE:
  - raw_any=0 -> IDLE.
  - raw_code!=cand -> cand<=raw_code, cnt<=0; remain in DEBOUNCE.
  - Match and cnt==DEBOUNCE_CYCLES-1 -> PRESSED; D<=cand, V<=0; raise press event.
  - Otherwise cnt<=cnt+1.
- Press latency: with a key stable from the first sampling edge, D and V update on edge DEBOUNCE_CYCLES+1. Example: default parameters give 5 edges.
- State PRESSED:
  - D and V held.
  - raw_any=0 or raw_code!=D -> RELEASE, cnt<=0.
- State RELEASE:
  - raw_any && raw_code==D -> back to PRESSED. This is a glitch: no new event is raised.
  - Any other input counts as released.
  - When cnt==DEBOUNCE_CYCLES-1 and still released -> IDLE, D<=0, V<=1.
  - Otherwise cnt<=cnt+1.
  - A different key seen during RELEASE is debounced fresh only after returning to IDLE. No key rollover.
- Press event: raised only on the DEBOUNCE->PRESSED transition.
  - If evt_valid=0, or evt_ack=1 in the same cycle: evt_valid<=1, evt_code<=cand.
  - Otherwise the event is dropped, overrun<=1, and evt_code is unchanged.
  - overrun is cleared only by reset.
- evt_ack=1 with evt_valid=1 and no new event clears evt_valid on that edge. evt_ack with evt_valid=0 is ignored.
- Counter width: CNT_W = max(1, clog2(DEBOUNCE_CYCLES)). The counter never wraps; it is bounded by the compare.
- Keypad bits at index >= NUM_KEYS do not exist. Codes beyond NUM_KEYS-1 are never produced.

Decomposition:
- Shared package keypad_pkg contains:
  - state enum: IDLE, DEBOUNCE, PRESSED, RELEASE (2-bit)
  - localparams for the CNT_W derivation
  - NO_KEY_V = 1'b1
- Sub-module keypad_prio_enc: purely combinational, parametrised NUM_KEYS/CODE_W, outputs raw_any and raw_code. It is the direct generalisation of the existing 10-key encoder.
- The top level holds the FSM, counter and event handshake.

Test Plan:
1. Reset, then keypad=10'b00_0010_0000 held with enablen=0 -> D=5, V=0 on edge 5 after first sample; evt_valid=1, evt_code=5. Assert evt_ack for 1 cycle -> evt_valid=0 on next edge.
2. Multiple keys: keypad bits 9 and 3 held -> D=9, with priority exactly as in the combinational encoder. Release both -> V=1, D=0 exactly 4 edges after the first released sample.
3. Bounce: key 7 toggles high 2 cycles, low 1, high 6 -> exactly one event, evt_code=7. A 2-cycle dropout while PRESSED -> D stays 7, no second event.
4. Candidate change in DEBOUNCE: key 2 for 2 cycles, then key 8 held -> counter restarts; D=8 after 5 edges from the key 8 onset. No event is ever raised for 2.
5. Overrun: two debounced presses (3, then 6) with no evt_ack -> evt_code stays 3, overrun=1. Press while ack is asserted in the same cycle -> new code loaded, no overrun.
6. enablen=1 mid-PRESSED -> D=0, V=1 next edge while evt_valid is retained. reset asserted mid-DEBOUNCE -> all outputs return to reset values on that edge.

Source files
------------

// File: rtl/keypad_debounce_encoder_pkg.sv
// Shared types and constants for the keypad debounce encoder.
package keypad_pkg;

    // Debounce FSM states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } kp_state_e;

    // Legacy sense of V: high means no key held
    localparam logic NO_KEY_V = 1'b1;

    // Counter width: max(1, clog2(cycles)); counter is bounded by compare, never wraps
    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_CNT_W           = cnt_width(DEF_DEBOUNCE_CYCLES);

endpackage

// File: rtl/keypad_debounce_encoder_prio_enc.sv
// Combinational priority encoder: highest set key index wins.
module keypad_prio_enc #(
    parameter int NUM_KEYS = 10,
    parameter int CODE_W   = 4
) (
    input  logic [NUM_KEYS-1:0] keypad_i,
    output logic                raw_any_o,
    output logic [CODE_W-1:0]   raw_code_o
);

    // Ascending scan so the last (highest) set bit overrides lower ones
    always_comb begin
        raw_any_o  = 1'b0;
        raw_code_o = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (keypad_i[i]) begin
                raw_any_o  = 1'b1;
                raw_code_o = CODE_W'(i);
            end
        end
    end

endmodule

// File: rtl/keypad_debounce_encoder.sv
// Keypad encoder with press/release debounce and a one-deep press event
// handshake. V and enablen keep the legacy active-low sense.
module keypad_debounce_encoder
    import keypad_pkg::*;
#(
    parameter int NUM_KEYS        = 10,
    parameter int CODE_W          = 4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keypad,
    input  logic                enablen,
    input  logic                evt_ack,
    output logic [CODE_W-1:0]   D,
    output logic                V,
    output logic                evt_valid,
    output logic [CODE_W-1:0]   evt_code,
    output logic                overrun
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic              raw_any;
    logic [CODE_W-1:0] raw_code;

    kp_state_e         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CODE_W-1:0] cand_q;
    logic [CODE_W-1:0] d_q;
    logic              v_q;
    logic              evt_valid_q;
    logic [CODE_W-1:0] evt_code_q;
    logic              overrun_q;
    logic              press_fire;

    keypad_prio_enc #(
        .NUM_KEYS (NUM_KEYS),
        .CODE_W   (CODE_W)
    ) u_enc (
        .keypad_i   (keypad),
        .raw_any_o  (raw_any),
        .raw_code_o (raw_code)
    );

    // A debounced press completes on this edge (DEBOUNCE -> PRESSED)
    always_comb begin
        press_fire = !enablen && (state_q == DEBOUNCE) && raw_any &&
                     (raw_code == cand_q) && (cnt_q == CNT_LAST);
    end

    // Debounce FSM, held code and press event handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= '0;
            d_q         <= '0;
            v_q         <= NO_KEY_V;
            evt_valid_q <= 1'b0;
            evt_code_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            // Event slot: a same-cycle ack frees the slot for the new press
            if (press_fire) begin
                if (!evt_valid_q || evt_ack) begin
                    evt_valid_q <= 1'b1;
                    evt_code_q  <= cand_q;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (evt_ack && evt_valid_q) begin
                evt_valid_q <= 1'b0;
            end

            if (enablen) begin
                // Disabled: drop key tracking but leave the event slot alone
                state_q <= IDLE;
                cnt_q   <= '0;
                d_q     <= '0;
                v_q     <= NO_KEY_V;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (raw_any) begin
                            cand_q  <= raw_code;
                            cnt_q   <= '0;
                            state_q <= DEBOUNCE;
                        end
                    end
                    DEBOUNCE: begin
                        if (!raw_any) begin
                            state_q <= IDLE;
                        end else if (raw_code != cand_q) begin
                            cand_q <= raw_code;
                            cnt_q  <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= PRESSED;
                            d_q     <= cand_q;
                            v_q     <= ~NO_KEY_V;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (!raw_any || (raw_code != d_q)) begin
                            state_q <= RELEASE;
                            cnt_q   <= '0;
                        end
                    end
                    RELEASE: begin
                        // Same key back before the count expires is a glitch
                        if (raw_any && (raw_code == d_q)) begin
                            state_q <= PRESSED;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= IDLE;
                            d_q     <= '0;
                            v_q     <= NO_KEY_V;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign D         = d_q;
    assign V         = v_q;
    assign evt_valid = evt_valid_q;
    assign evt_code  = evt_code_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_debounce_encoder.sv
// Directed bench for keypad_debounce_encoder with default parameters.
module tb_keypad_debounce_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] keypad;
    logic       enablen;
    logic       evt_ack;
    logic [3:0] D;
    logic       V;
    logic       evt_valid;
    logic [3:0] evt_code;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    keypad_debounce_encoder #(
        .NUM_KEYS        (10),
        .CODE_W          (4),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .keypad    (keypad),
        .enablen   (enablen),
        .evt_ack   (evt_ack),
        .D         (D),
        .V         (V),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            $error("check %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] d, input logic v,
                           input logic ev, input logic [3:0] ec, input logic ov);
        chk({tag, ".D"}, 32'(D), 32'(d));
        chk({tag, ".V"}, 32'(V), 32'(v));
        chk({tag, ".evt_valid"}, 32'(evt_valid), 32'(ev));
        chk({tag, ".evt_code"}, 32'(evt_code), 32'(ec));
        chk({tag, ".overrun"}, 32'(overrun), 32'(ov));
    endtask

    initial begin
        reset = 1'b1; keypad = '0; enablen = 1'b0; evt_ack = 1'b0;
        tick(2);
        reset = 1'b0;
        chk_all("reset", 4'd0, 1'b1, 1'b0, 4'd0, 1'b0);

        // 1: single key 5, press latency 5 edges, ack clears event
        keypad = 10'b00_0010_0000;
        tick(4);
        chk("t1.before_latency.V", 32'(V), 32'd1);
        tick(1);
        chk_all("t1.pressed", 4'd5, 1'b0, 1'b1, 4'd5, 1'b0);
        evt_ack = 1'b1;
        tick(1);
        evt_ack = 1'b0;
        chk("t1.ack.evt_valid", 32'(evt_valid), 32'd0);
        keypad = '0;
        tick(5);
        chk("t1.release.V", 32'(V), 32'd1);

        // 2: keys 9 and 3 together -> 9; release after 5 edges incl. first sample
        keypad = 10'b10_0000_1000;
        tick(5);
        chk_all("t2.pressed", 4'd9, 1'b0, 1'b1, 4'd9, 1'b0);
        evt_ack = 1'b1;
        tick(1);
        evt_ack = 1'b0;
        chk("t2.ack.evt_valid", 32'(evt_valid), 32'd0);
        keypad = '0;
        tick(4);
        chk("t2.release_early.V", 32'(V), 32'd0);
        chk("t2.release_early.D", 32'(D), 32'd9);
        tick(1);
        chk("t2.released.V", 32'(V), 32'd1);
        chk("t2.released.D", 32'(D), 32'd0);

        // 3: key 7 bounce high 2 / low 1 / high 6, then a 2-cycle dropout
        keypad = 10'b00_1000_0000;
        tick(2);
        keypad = '0;
        tick(1);
        keypad = 10'b00_1000_0000;
        tick(4);
        chk("t3.bounce_early.V", 32'(V), 32'd1);
        chk("t3.bounce_early.evt_valid", 32'(evt_valid), 32'd0);
        tick(1);
        chk_all("t3.pressed", 4'd7, 1'b0, 1'b1, 4'd7, 1'b0);
        tick(1);
        keypad = '0;
        tick(2);
        chk("t3.dropout.D", 32'(D), 32'd7);
        chk("t3.dropout.V", 32'(V), 32'd0);
        keypad = 10'b00_1000_0000;
        tick(5);
        chk_all("t3.after_glitch", 4'd7, 1'b0, 1'b1, 4'd7, 1'b0);
        evt_ack = 1'b1;
        tick(1);
        evt_ack = 1'b0;
        chk("t3.ack.evt_valid", 32'(evt_valid), 32'd0);
        keypad = '0;
        tick(5);
        chk("t3.released.V", 32'(V), 32'd1);

        // 4: key 2 for 2 cycles then key 8 -> counter restarts at key 8 onset
        keypad = 10'b00_0000_0100;
        tick(2);
        keypad = 10'b01_0000_0000;
        tick(4);
        chk("t4.early.V", 32'(V), 32'd1);
        chk("t4.early.evt_valid", 32'(evt_valid), 32'd0);
        tick(1);
        chk_all("t4.pressed", 4'd8, 1'b0, 1'b1, 4'd8, 1'b0);
        evt_ack = 1'b1;
        tick(1);
        evt_ack = 1'b0;
        keypad = '0;
        tick(5);
        chk("t4.released.V", 32'(V), 32'd1);

        // 5: press 3 unacked; press 6 with same-cycle ack; press 5 unacked -> overrun
        keypad = 10'b00_0000_1000;
        tick(5);
        chk_all("t5.press3", 4'd3, 1'b0, 1'b1, 4'd3, 1'b0);
        keypad = '0;
        tick(5);
        keypad = 10'b00_0100_0000;
        tick(4);
        evt_ack = 1'b1;
        tick(1);
        evt_ack = 1'b0;
        chk_all("t5.press6_ack", 4'd6, 1'b0, 1'b1, 4'd6, 1'b0);
        keypad = '0;
        tick(5);
        keypad = 10'b00_0010_0000;
        tick(5);
        chk_all("t5.press5_drop", 4'd5, 1'b0, 1'b1, 4'd6, 1'b1);

        // 6: enablen mid-PRESSED, then reset mid-DEBOUNCE
        enablen = 1'b1;
        tick(1);
        chk_all("t6.disabled", 4'd0, 1'b1, 1'b1, 4'd6, 1'b1);
        enablen = 1'b0;
        tick(2);
        chk("t6.rearm.V", 32'(V), 32'd1);
        reset = 1'b1;
        tick(1);
        chk_all("t6.reset", 4'd0, 1'b1, 1'b0, 4'd0, 1'b0);
        reset = 1'b0;
        keypad = '0;
        evt_ack = 1'b1;
        tick(1);
        evt_ack = 1'b0;
        chk("t6.idle_ack.evt_valid", 32'(evt_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
